// File: rtl/periph_apb_bridge.sv
// periph_apb_bridge: bridges the core data-memory port onto an APB-style
// peripheral bus with per-slave chip selects, wait states and error replies
// for unmapped addresses.
// Optional build macro: BRIDGE_TIMEOUT_EN aborts an ACCESS phase that waits
// TIMEOUT cycles without pready and reports it as an error.
module periph_apb_bridge #(
  parameter int unsigned NSLV    = 4,
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      psel,
  output logic                 pwrite,
  output logic                 penable,
  output logic [31:0]          paddr,
  output logic [31:0]          pwdata,
  input  logic [32*NSLV-1:0]   prdata,
  input  logic [NSLV-1:0]      pready
);

  if (NSLV < 1 || NSLV > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("periph_apb_bridge: NSLV must be 1..16 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] sel_rdata;
  logic        sel_ready;
  logic        hit;
  logic        timeout_hit;

  assign hit = (cpu_addr[31:16] == BASE_HI) && (32'(cpu_addr[15:12]) < NSLV);

  // Route the addressed slave's read data and ready back to the bridge.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (idx_q == 4'(k)) begin
        sel_rdata = prdata[32*k +: 32];
        sel_ready = pready[k];
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count ACCESS cycles without ready; cleared when a new transfer is accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // The edge that would bring the count to TIMEOUT ends the transfer instead.
  assign timeout_hit = (state_q == ACCESS) && !sel_ready && (cnt_q == CW'(TIMEOUT - 1));

  // Wait-state counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and transfer bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          paddr_d  = cpu_addr;
          pwdata_d = cpu_wdata;
          pwrite_d = cpu_we;
          idx_d    = cpu_addr[15:12];
          rdata_d  = '0;
          if (hit) begin
            err_d   = 1'b0;
            state_d = SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = pwrite_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched bus/response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Chip select decoded from state so reset removes it without a clock.
  always_comb begin
    psel = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      psel[k] = ((state_q == SETUP) || (state_q == ACCESS)) && (idx_q == 4'(k));
    end
  end

  assign penable   = (state_q == ACCESS);
  assign cpu_ready = (state_q == RESP);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;

endmodule

// File: tb/tb_periph_apb_bridge.sv
// Randomised bench for periph_apb_bridge: each transfer's expected bus
// timeline and response come from a transaction-level model of the bridge.
module tb_periph_apb_bridge;

  localparam int unsigned NSLV    = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cpu_req = 1'b0;
  logic                cpu_we = 1'b0;
  logic [31:0]         cpu_addr = '0;
  logic [31:0]         cpu_wdata = '0;
  logic [31:0]         cpu_rdata;
  logic                cpu_ready;
  logic                cpu_err;
  logic [NSLV-1:0]     psel;
  logic                pwrite;
  logic                penable;
  logic [31:0]         paddr;
  logic [31:0]         pwdata;
  logic [32*NSLV-1:0]  prdata = '0;
  logic [NSLV-1:0]     pready = '1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  periph_apb_bridge #(.NSLV(NSLV), .BASE_HI(16'h1000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .psel(psel), .pwrite(pwrite), .penable(penable), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One idle cycle with the request dropped; also proves cpu_ready was a single pulse.
  task automatic idle_gap();
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("gap_idle", {cpu_ready, psel, penable}, '0);
  endtask

  // Called #1 after a rising edge. The reference timeline: mapped access
  // spends 1 SETUP cycle, waits+1 ACCESS cycles (or TIMEOUT when aborted),
  // then 1 RESP cycle; an unmapped access goes straight to RESP.
  task automatic xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int unsigned waits, input logic [31:0] rd_val, input bit b2b);
    bit              hit, abort;
    int unsigned     idx, acc, ready_n;
    logic [31:0]     exp_rd;
    logic [NSLV-1:0] exp_sel;
    idx   = 32'(addr[15:12]);
    hit   = (addr[31:16] == 16'h1000) && (idx < NSLV);
    abort = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    abort = hit && (waits >= TIMEOUT);
`endif
    acc     = abort ? TIMEOUT : waits + 1;
    ready_n = hit ? 2 + acc : 1;
    exp_sel = '0;
    if (hit) exp_sel[idx] = 1'b1;
    exp_rd  = (hit && !we && !abort) ? rd_val : 32'h0;

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int k = 0; k < NSLV; k++) begin
      prdata[32*k +: 32] = $urandom;
      pready[k]          = 1'($urandom % 2);
    end
    if (hit) begin
      prdata[32*idx +: 32] = rd_val;
      pready[idx]          = 1'b0;
    end

    if (b2b) begin
      // Request held through RESP must not be taken until the bridge is idle.
      @(posedge clk); #1;
      check("b2b_idle", {cpu_ready, psel, penable}, '0);
    end

    for (int unsigned n = 1; n <= ready_n; n++) begin
      @(posedge clk); #1;
      if (n < ready_n) begin
        check("ready_early", cpu_ready, 1'b0);
        check("psel_pen", {psel, penable}, {exp_sel, n >= 2});
        check("paddr_hold", paddr, addr);
        check("pwd_hold", {pwdata, pwrite}, {wdata, we});
        if (hit && n >= 2) pready[idx] = (n - 1 > waits);
      end else begin
        check("ready", cpu_ready, 1'b1);
        check("err", cpu_err, !hit || abort);
        check("rdata", cpu_rdata, exp_rd);
        check("resp_bus", {psel, penable}, '0);
      end
    end
  endtask

  initial begin
    logic [31:0] lo;
    logic [31:0] addr;
    int unsigned sel;
    bit          b2b;

    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_state", {psel, penable, pwrite, cpu_ready, cpu_err}, '0);
    check("rst_regs", {paddr, pwdata}, '0);
    check("rst_rdata", cpu_rdata, '0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    xfer(1'b1, 32'h1000_0000, 32'h0000_00FF, 0, 32'h1234_5678, 1'b0);
    idle_gap();
    xfer(1'b0, 32'h1000_1008, 32'h0, 2, 32'hA5A5_0003, 1'b0);
    idle_gap();
    xfer(1'b0, 32'h1000_5000, 32'h0, 0, 32'h0, 1'b0);
    idle_gap();
    xfer(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h1000_2004, 32'h0, 1, 32'hCAFE_0001, 1'b1);
    idle_gap();
    xfer(1'b0, 32'h1000_3000, 32'h0, 110, 32'h0BAD_F00D, 1'b0);
    idle_gap();

    // Asynchronous reset in the middle of ACCESS.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_3010; pready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pre_access", {psel, penable}, {4'b1000, 1'b1});
    #2 reset = 1'b0;
    #1 check("rst_async", {psel, penable, cpu_ready}, '0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rst_no_ready", {cpu_ready, psel, penable}, '0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h1000_2abc, 32'h0, 0, 32'h7777_0002, 1'b0);

    for (int t = 0; t < 60; t++) begin
      sel = $urandom % 8;
      lo  = $urandom % 4096;
      case (sel)
        5:       addr = {16'h1000, 4'(4 + $urandom % 12), lo[11:0]};
        6:       addr = {16'h1000 ^ 16'(1 + $urandom % 65535), 4'($urandom), lo[11:0]};
        default: addr = {16'h1000, 4'($urandom % NSLV), lo[11:0]};
      endcase
      b2b = ($urandom % 3 == 0);
      if (!b2b) idle_gap();
      xfer(1'($urandom), addr, $urandom, $urandom % 4, $urandom, b2b);
    end
    idle_gap();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
